// File: rtl/lsu_req_buffer_pkg.sv
// Shared definitions for the LSU request buffer.
// - Size encodings for byte, half, word and dword.
// - Byte-strobe and write-data replication helpers. Both work at a 64-bit
//   width; callers truncate the result to their own bus width.
// - Width of a packed queue entry.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Returns (2^(2^size) - 1) << off. An aligned access never shifts bits
    // past its own bus width, so truncating the result is lossless.
    function automatic logic [15:0] strobe_of(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] base;
        case (size)
            SZ_B:    base = 16'h0001;
            SZ_H:    base = 16'h0003;
            SZ_W:    base = 16'h000F;
            default: base = 16'h00FF;
        endcase
        return base << off;
    endfunction

    // Replicates the low 8<<size bits of d across 64 bits. The low 32 bits of
    // the result are also the correct lane image for a 32-bit bus.
    function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] d);
        case (size)
            SZ_B:    return {8{d[7:0]}};
            SZ_H:    return {4{d[15:0]}};
            SZ_W:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    // Entry layout is {store, size, addr, wstrb, wdata, tag}.
    function automatic int entry_w(input int data_w, input int addr_w, input int tag_w);
        return 1 + 2 + addr_w + data_w / 8 + data_w + tag_w;
    endfunction

endpackage

// File: rtl/lsu_req_buffer_if.sv
// EX-side request, ALE report and cache request signals of the LSU buffer.
// slave  : the buffer's view (takes in_*, drives in_ready, ale_*, data_*, count, empty)
// master : the environment's view (EX stage plus cache port)
interface lsu_req_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_store;
    logic [1:0]        in_size;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [TAG_W-1:0]  in_tag;

    logic              ale_valid;
    logic [ADDR_W-1:0] ale_addr;
    logic [TAG_W-1:0]  ale_tag;

    logic              data_valid;
    logic              data_op;
    logic [2:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [NB-1:0]     data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;

    logic [CW-1:0]     count;
    logic              empty;

    modport slave (
        input  in_valid, in_store, in_size, in_addr, in_wdata, in_tag, data_addr_ok,
        output in_ready, ale_valid, ale_addr, ale_tag,
               data_valid, data_op, data_size, data_addr, data_wstrb, data_wdata,
               count, empty
    );

    modport master (
        output in_valid, in_store, in_size, in_addr, in_wdata, in_tag, data_addr_ok,
        input  in_ready, ale_valid, ale_addr, ale_tag,
               data_valid, data_op, data_size, data_addr, data_wstrb, data_wdata,
               count, empty
    );
endinterface

// File: rtl/lsu_req_buffer_fifo.sv
// Circular queue of DEPTH entries with an occupancy count.
// Ports: clk, reset (async high), clear (sync), push/wdata, pop, rdata (head,
// forced to zero while empty), count, full, empty.
// The caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage is not reset; rdata is masked so a stale slot never shows.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/lsu_req_buffer.sv
// Load/store request buffer between EX address generation and the D-cache.
// Ports: clk, reset (async high), flush (sync clear), bus (slave modport):
//   in_*      request from EX, accepted when in_valid && in_ready
//   ale_*     one-cycle report of a misaligned/illegal request
//   data_*    head-of-queue cache request, popped on data_addr_ok
//   count/empty occupancy
// Strobe and lane data are computed at enqueue and stored with the entry.
module lsu_req_buffer
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5
) (
    input logic clk,
    input logic reset,
    input logic flush,
    lsu_req_buffer_if.slave bus
);
    localparam int NB      = DATA_W / 8;
    localparam int OFFW    = $clog2(NB);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = entry_w(DATA_W, ADDR_W, TAG_W);

    typedef struct packed {
        logic              store;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [NB-1:0]     wstrb;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t        in_entry;
    entry_t        head;
    logic [ENTRY_W-1:0] head_raw;
    logic [2:0]    amask;
    logic [2:0]    off;
    logic          mis;
    logic          acc;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    // Low address bits that must be zero for the access to be aligned.
    always_comb begin
        case (bus.in_size)
            SZ_B:    amask = 3'b000;
            SZ_H:    amask = 3'b001;
            SZ_W:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    assign mis = (|(bus.in_addr[2:0] & amask))
               || (DATA_W == 32 && bus.in_size == SZ_D);
    assign off = 3'(bus.in_addr[OFFW-1:0]);

    always_comb begin
        in_entry.store = bus.in_store;
        in_entry.size  = bus.in_size;
        in_entry.addr  = bus.in_addr;
        in_entry.wstrb = NB'(strobe_of(bus.in_size, off));
        in_entry.wdata = DATA_W'(replicate(bus.in_size, 64'(bus.in_wdata)));
        in_entry.tag   = bus.in_tag;
    end

    // A full queue stalls even if the head pops this cycle.
    assign bus.in_ready = !full && !flush;
    assign acc  = bus.in_valid && bus.in_ready;
    assign push = acc && !mis;
    assign pop  = bus.data_valid && bus.data_addr_ok;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .wdata (in_entry),
        .pop   (pop),
        .rdata (head_raw),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head = entry_t'(head_raw);

    assign bus.data_valid = !empty && !flush;
    assign bus.data_op    = head.store;
    assign bus.data_size  = {1'b0, head.size};
    assign bus.data_addr  = head.addr;
    assign bus.data_wstrb = head.wstrb;
    assign bus.data_wdata = head.wdata;
    assign bus.count      = count;
    assign bus.empty      = empty;

    // ALE report: address/tag hold their last value; only valid is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ale_valid <= 1'b0;
            bus.ale_addr  <= '0;
            bus.ale_tag   <= '0;
        end else if (flush) begin
            bus.ale_valid <= 1'b0;
        end else if (acc && mis) begin
            bus.ale_valid <= 1'b1;
            bus.ale_addr  <= bus.in_addr;
            bus.ale_tag   <= bus.in_tag;
        end else begin
            bus.ale_valid <= 1'b0;
        end
    end

    // head.tag travels with the entry but the cache port has no tag field.
    logic unused_tag;
    assign unused_tag = ^head.tag;
endmodule

// File: tb/tb_lsu_req_buffer.sv
// Directed bench for lsu_req_buffer: a vector table for single requests on
// 32- and 64-bit instances, plus hand sequences for fill/drain, push+pop,
// flush and asynchronous reset.
module tb_lsu_req_buffer;
    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    lsu_req_buffer_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .TAG_W(5)) ifa ();
    lsu_req_buffer_if #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .TAG_W(5)) ifb ();

    lsu_req_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .TAG_W(5)) u32 (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifa.slave));
    lsu_req_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .TAG_W(5)) u64 (
        .clk(clk), .reset(reset), .flush(flush), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          w64;
        bit          store;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [4:0]  tag;
        bit          mis;
        logic [7:0]  wstrb;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.in_valid = 0; ifa.in_store = 0; ifa.in_size = 0;
        ifa.in_addr = 0; ifa.in_wdata = 0; ifa.in_tag = 0;
    endtask

    task automatic drive_a(input bit st, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] t);
        ifa.in_valid = 1; ifa.in_store = st; ifa.in_size = sz;
        ifa.in_addr = a; ifa.in_wdata = d; ifa.in_tag = t;
    endtask

    // One request into an empty queue with addr_ok high: issue (or ALE) in
    // the cycle after acceptance, then empty / ALE gone one cycle later.
    task automatic run_vec(input vec_t v, input int idx);
        logic        dv, av, op, emp, rdy;
        logic [2:0]  dsz;
        logic [31:0] da, aa;
        logic [7:0]  ws;
        logic [63:0] wd;
        logic [4:0]  at;
        string       p;
        p = $sformatf("v%0d", idx);
        if (v.w64) begin
            ifb.in_valid = 1; ifb.in_store = v.store; ifb.in_size = v.size;
            ifb.in_addr = v.addr; ifb.in_wdata = v.wdata; ifb.in_tag = v.tag;
        end else begin
            drive_a(v.store, v.size, v.addr, v.wdata[31:0], v.tag);
        end
        #1;
        rdy = v.w64 ? ifb.in_ready : ifa.in_ready;
        chk({p, "_in_ready"}, 64'(rdy), 64'(1));
        tick();
        ifb.in_valid = 0;
        ifa.in_valid = 0;
        #1;
        if (v.w64) begin
            dv = ifb.data_valid; av = ifb.ale_valid; op = ifb.data_op; dsz = ifb.data_size;
            da = ifb.data_addr; ws = ifb.data_wstrb; wd = ifb.data_wdata;
            aa = ifb.ale_addr; at = ifb.ale_tag;
        end else begin
            dv = ifa.data_valid; av = ifa.ale_valid; op = ifa.data_op; dsz = ifa.data_size;
            da = ifa.data_addr; ws = 8'(ifa.data_wstrb); wd = 64'(ifa.data_wdata);
            aa = ifa.ale_addr; at = ifa.ale_tag;
        end
        if (v.mis) begin
            chk({p, "_ale_valid"}, 64'(av), 64'(1));
            chk({p, "_ale_addr"}, 64'(aa), 64'(v.addr));
            chk({p, "_ale_tag"}, 64'(at), 64'(v.tag));
            chk({p, "_no_issue"}, 64'(dv), 64'(0));
        end else begin
            chk({p, "_data_valid"}, 64'(dv), 64'(1));
            chk({p, "_ale_quiet"}, 64'(av), 64'(0));
            chk({p, "_op"}, 64'(op), 64'(v.store));
            chk({p, "_size"}, 64'(dsz), 64'({1'b0, v.size}));
            chk({p, "_addr"}, 64'(da), 64'(v.addr));
            chk({p, "_wstrb"}, 64'(ws), 64'(v.wstrb));
            chk({p, "_wdata"}, wd, v.exp_wdata);
        end
        tick();
        emp = v.w64 ? ifb.empty : ifa.empty;
        av  = v.w64 ? ifb.ale_valid : ifa.ale_valid;
        chk({p, "_empty_after"}, 64'(emp), 64'(1));
        chk({p, "_ale_drop"}, 64'(av), 64'(0));
    endtask

    initial begin
        reset = 1; flush = 0;
        idle_a();
        ifa.data_addr_ok = 1;
        ifb.in_valid = 0; ifb.in_store = 0; ifb.in_size = 0;
        ifb.in_addr = 0; ifb.in_wdata = 0; ifb.in_tag = 0;
        ifb.data_addr_ok = 1;

        //            w64 st size  addr          wdata                  tag  mis wstrb  exp_wdata
        vecs.push_back('{0, 1, 2'd2, 32'h1000, 64'h11223344,          5'd1, 0, 8'h0F, 64'h11223344});
        vecs.push_back('{0, 1, 2'd0, 32'h1003, 64'h000000AB,          5'd2, 0, 8'h08, 64'hABABABAB});
        vecs.push_back('{0, 1, 2'd1, 32'h1002, 64'h0000BEEF,          5'd3, 0, 8'h0C, 64'hBEEFBEEF});
        vecs.push_back('{0, 0, 2'd1, 32'h1001, 64'h0,                 5'd9, 1, 8'h00, 64'h0});
        vecs.push_back('{0, 0, 2'd3, 32'h1000, 64'h0,                 5'd10, 1, 8'h00, 64'h0});
        vecs.push_back('{0, 0, 2'd0, 32'h1001, 64'h12345678,          5'd4, 0, 8'h02, 64'h78787878});
        vecs.push_back('{0, 1, 2'd1, 32'h1000, 64'h0000CAFE,          5'd5, 0, 8'h03, 64'hCAFECAFE});
        vecs.push_back('{0, 0, 2'd2, 32'h1002, 64'h0,                 5'd11, 1, 8'h00, 64'h0});
        vecs.push_back('{1, 1, 2'd3, 32'h2008, 64'h0123456789ABCDEF,  5'd6, 0, 8'hFF, 64'h0123456789ABCDEF});
        vecs.push_back('{1, 1, 2'd2, 32'h2004, 64'hCAFEF00D,          5'd7, 0, 8'hF0, 64'hCAFEF00DCAFEF00D});
        vecs.push_back('{1, 1, 2'd0, 32'h2007, 64'h5A,                5'd8, 0, 8'h80, 64'h5A5A5A5A5A5A5A5A});
        vecs.push_back('{1, 1, 2'd1, 32'h2006, 64'h1234,              5'd12, 0, 8'hC0, 64'h1234123412341234});
        vecs.push_back('{1, 0, 2'd3, 32'h2004, 64'h0,                 5'd13, 1, 8'h00, 64'h0});
        vecs.push_back('{1, 0, 2'd2, 32'h2002, 64'h0,                 5'd14, 1, 8'h00, 64'h0});

        #12;
        reset = 0;
        tick();

        // Reset state.
        chk("rst_count", 64'(ifa.count), 64'(0));
        chk("rst_empty", 64'(ifa.empty), 64'(1));
        chk("rst_in_ready", 64'(ifa.in_ready), 64'(1));
        chk("rst_data_valid", 64'(ifa.data_valid), 64'(0));
        chk("rst_ale", 64'({ifa.ale_valid, ifa.ale_addr, ifa.ale_tag}), 64'(0));
        chk("rst_wstrb", 64'(ifa.data_wstrb), 64'(0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Fill to DEPTH with the cache stalled, then drain in order.
        ifa.data_addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            drive_a(1, 2'd2, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 5'(i));
            tick();
        end
        drive_a(1, 2'd2, 32'h110, 32'hA4, 5'd4);
        #1;
        chk("full_count", 64'(ifa.count), 64'(4));
        chk("full_in_ready", 64'(ifa.in_ready), 64'(0));
        chk("full_head_addr", 64'(ifa.data_addr), 64'h100);
        tick();
        chk("stall_count", 64'(ifa.count), 64'(4));
        chk("stall_head_addr", 64'(ifa.data_addr), 64'h100);
        chk("stall_head_wdata", 64'(ifa.data_wdata), 64'hA0);
        idle_a();
        ifa.data_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain%0d_valid", i), 64'(ifa.data_valid), 64'(1));
            chk($sformatf("drain%0d_addr", i), 64'(ifa.data_addr), 64'(32'h100 + 32'(4 * i)));
            chk($sformatf("drain%0d_wdata", i), 64'(ifa.data_wdata), 64'(32'hA0 + 32'(i)));
            tick();
        end
        chk("drain_empty", 64'(ifa.empty), 64'(1));
        chk("drain_data_valid", 64'(ifa.data_valid), 64'(0));

        // Push and pop in the same cycle at count 2.
        ifa.data_addr_ok = 0;
        drive_a(1, 2'd2, 32'h200, 32'h1, 5'd0); tick();
        drive_a(1, 2'd2, 32'h204, 32'h2, 5'd0); tick();
        drive_a(1, 2'd2, 32'h208, 32'h3, 5'd0);
        ifa.data_addr_ok = 1;
        tick();
        idle_a();
        ifa.data_addr_ok = 0;
        #1;
        chk("pp_count", 64'(ifa.count), 64'(2));
        chk("pp_head_addr", 64'(ifa.data_addr), 64'h204);
        ifa.data_addr_ok = 1;
        tick();
        chk("pp_second_addr", 64'(ifa.data_addr), 64'h208);
        tick();
        chk("pp_empty", 64'(ifa.empty), 64'(1));

        // Flush with three queued and a request offered.
        ifa.data_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            drive_a(1, 2'd2, 32'h300 + 32'(4 * i), 32'(i), 5'd0);
            tick();
        end
        chk("pre_flush_count", 64'(ifa.count), 64'(3));
        drive_a(1, 2'd2, 32'h30C, 32'h9, 5'd0);
        flush = 1;
        #1;
        chk("flush_data_valid", 64'(ifa.data_valid), 64'(0));
        chk("flush_in_ready", 64'(ifa.in_ready), 64'(0));
        tick();
        flush = 0;
        idle_a();
        #1;
        chk("post_flush_count", 64'(ifa.count), 64'(0));
        chk("post_flush_empty", 64'(ifa.empty), 64'(1));
        tick();
        chk("post_flush_dropped", 64'(ifa.data_valid), 64'(0));

        // Asynchronous reset while issuing with an ALE pending.
        drive_a(1, 2'd2, 32'h400, 32'h55, 5'd0); tick();
        drive_a(1, 2'd2, 32'h404, 32'h66, 5'd0); tick();
        drive_a(0, 2'd1, 32'h1001, 32'h0, 5'd7); tick();
        idle_a();
        #1;
        chk("pre_rst_ale", 64'(ifa.ale_valid), 64'(1));
        chk("pre_rst_valid", 64'(ifa.data_valid), 64'(1));
        chk("pre_rst_count", 64'(ifa.count), 64'(2));
        reset = 1;
        #1;
        chk("arst_data_valid", 64'(ifa.data_valid), 64'(0));
        chk("arst_count", 64'(ifa.count), 64'(0));
        chk("arst_ale", 64'({ifa.ale_valid, ifa.ale_addr, ifa.ale_tag}), 64'(0));
        chk("arst_head", 64'({ifa.data_addr, ifa.data_wstrb}), 64'(0));
        chk("arst_wdata", 64'(ifa.data_wdata), 64'(0));
        #1;
        reset = 0;
        tick();
        chk("after_rst_empty", 64'(ifa.empty), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
